// File: rtl/pool_stream.sv
// Streaming max/average pooling over fixed-size windows of signed fixed-point samples.
// One sample per cycle in, one pooled result per window out, with a single-entry output register.
module pool_stream #(
   parameter int INTEGER_BITS     = 9,
   parameter int FIXED_POINT_BITS = 4,
   parameter int WINDOW           = 4,
   localparam int W = INTEGER_BITS + FIXED_POINT_BITS,
   localparam int L = $clog2(WINDOW)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   input  logic         mode,
   input  logic         flush,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready,
   output logic [L-1:0] win_cnt
);

   // Accumulator is W+L wide so a full window of sums can never overflow.
   logic signed [W+L-1:0] acc_q;
   logic signed [W+L-1:0] acc_next;
   logic signed [W+L-1:0] sample_ext;
   logic                  win_mode_q;
   logic                  eff_mode;
   logic                  first;
   logic                  last;
   logic                  accept;
   logic                  take;
   logic [W-1:0]          result;

   assign in_ready = rst_n & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;
   assign take     = out_valid & out_ready;
   assign first    = (win_cnt == '0);
   assign last     = (win_cnt == L'(WINDOW - 1));
   // The first sample of a window uses the live mode; later samples use the latched copy.
   assign eff_mode = first ? mode : win_mode_q;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      sample_ext = {{L{in_data[W-1]}}, in_data};
      acc_next   = acc_q;
      result     = '0;
      if (first) begin
         acc_next = sample_ext;
      end else if (eff_mode) begin
         acc_next = acc_q + sample_ext;
      end else if (sample_ext > acc_q) begin
         acc_next = sample_ext;
      end
      // Arithmetic shift floors toward negative infinity.
      result = eff_mode ? W'(acc_next >>> L) : acc_next[W-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         win_mode_q <= 1'b0;
         win_cnt    <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         if (take) begin
            out_valid <= 1'b0;
         end
         if (flush) begin
            win_cnt <= '0;
            acc_q   <= '0;
         end else if (accept) begin
            acc_q <= acc_next;
            if (first) begin
               win_mode_q <= mode;
            end
            if (last) begin
               win_cnt   <= '0;
               out_data  <= result;
               out_valid <= 1'b1;
            end else begin
               win_cnt <= win_cnt + L'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_pool_stream.sv
// Directed bench for pool_stream (W=13, WINDOW=4): max/average results, backpressure,
// flush, asynchronous reset and mid-window mode changes against hand-computed values.
module tb_pool_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [12:0] in_data;
   logic        in_ready;
   logic        mode;
   logic        flush;
   logic        out_valid;
   logic [12:0] out_data;
   logic        out_ready;
   logic [1:0]  win_cnt;

   int checks = 0;
   int errors = 0;

   pool_stream #(.INTEGER_BITS(9), .FIXED_POINT_BITS(4), .WINDOW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mode      (mode),
      .flush     (flush),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .win_cnt   (win_cnt)
   );

   always #5 clk = ~clk;

   // Offer one sample, wait (bounded) for in_ready, return #1 after the accepting edge.
   task automatic push(input logic [12:0] d, input logic m);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      mode     = m;
      #1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL push_timeout data=%h in_ready=%b expected 1", d, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 13'h0AAA;
      mode     = ~m;
   endtask

   task automatic test_reset;
      #3;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
      checks++;
      if (out_data !== 13'h0000) begin errors++; $display("FAIL reset_out_data got %h expected 0000", out_data); end
      checks++;
      if (win_cnt !== 2'd0) begin errors++; $display("FAIL reset_win_cnt got %0d expected 0", win_cnt); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b expected 1", in_ready); end
   endtask

   task automatic test_max;
      out_ready = 1'b1;
      push(13'h1FD0, 1'b0);
      checks++;
      if (win_cnt !== 2'd1) begin errors++; $display("FAIL max_win_cnt1 got %0d expected 1", win_cnt); end
      push(13'h1FF0, 1'b0);
      push(13'h1F80, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || win_cnt !== 2'd3) begin
         errors++; $display("FAIL max_mid got valid=%b cnt=%0d expected 0/3", out_valid, win_cnt);
      end
      push(13'h1FE0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 13'h1FF0 || win_cnt !== 2'd0) begin
         errors++; $display("FAIL max_neg got valid=%b data=%h cnt=%0d expected 1/1ff0/0", out_valid, out_data, win_cnt);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL max_drain got %b expected 0", out_valid); end
      // Full-range signed compare: most negative vs most positive.
      push(13'h1000, 1'b0);
      push(13'h0FFF, 1'b0);
      push(13'h0000, 1'b0);
      push(13'h1FFF, 1'b0);
      checks++;
      if (out_data !== 13'h0FFF) begin errors++; $display("FAIL max_extremes got %h expected 0fff", out_data); end
   endtask

   task automatic test_average;
      out_ready = 1'b1;
      push(13'h0010, 1'b1);
      push(13'h0020, 1'b1);
      push(13'h0030, 1'b1);
      push(13'h0050, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 13'h002C) begin
         errors++; $display("FAIL avg_pos got valid=%b data=%h expected 1/002c", out_valid, out_data);
      end
      push(13'h1FF0, 1'b1);
      push(13'h1FF0, 1'b1);
      push(13'h1FF0, 1'b1);
      push(13'h0000, 1'b1);
      checks++;
      if (out_data !== 13'h1FF4) begin errors++; $display("FAIL avg_neg got %h expected 1ff4", out_data); end
      // Sum of -1 LSB floors to -1 LSB, not 0.
      push(13'h1FFF, 1'b1);
      push(13'h0000, 1'b1);
      push(13'h0000, 1'b1);
      push(13'h0000, 1'b1);
      checks++;
      if (out_data !== 13'h1FFF) begin errors++; $display("FAIL avg_floor got %h expected 1fff", out_data); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      push(13'h0010, 1'b0);
      push(13'h0020, 1'b0);
      push(13'h0030, 1'b0);
      push(13'h0040, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 13'h0040 || in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_first got valid=%b data=%h ready=%b expected 1/0040/0", out_valid, out_data, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 13'h0050;
      mode     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 13'h0040 || win_cnt !== 2'd0) begin
         errors++; $display("FAIL bp_hold got valid=%b data=%h cnt=%0d expected 1/0040/0", out_valid, out_data, win_cnt);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || win_cnt !== 2'd1) begin
         errors++; $display("FAIL bp_release got valid=%b cnt=%0d expected 0/1", out_valid, win_cnt);
      end
      push(13'h0060, 1'b1);
      push(13'h0070, 1'b1);
      push(13'h0010, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 13'h0070) begin
         errors++; $display("FAIL bp_second got valid=%b data=%h expected 1/0070", out_valid, out_data);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_flush;
      // A pending result survives a flush.
      out_ready = 1'b0;
      repeat (4) push(13'h0020, 1'b0);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 13'h0020) begin
         errors++; $display("FAIL flush_pending got valid=%b data=%h expected 1/0020", out_valid, out_data);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      push(13'h0100, 1'b0);
      push(13'h0200, 1'b0);
      @(negedge clk);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 13'h0FFF;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (win_cnt !== 2'd0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_clear got cnt=%0d valid=%b expected 0/0", win_cnt, out_valid);
      end
      repeat (4) push(13'h0010, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 13'h0010 || win_cnt !== 2'd0) begin
         errors++; $display("FAIL flush_window got valid=%b data=%h cnt=%0d expected 1/0010/0", out_valid, out_data, win_cnt);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b1;
      push(13'h0010, 1'b1);
      push(13'h0020, 1'b1);
      push(13'h0030, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 13'h0000 || win_cnt !== 2'd0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL rst_async got valid=%b data=%h cnt=%0d ready=%b expected all 0", out_valid, out_data, win_cnt, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      push(13'h0040, 1'b1);
      push(13'h0040, 1'b1);
      push(13'h0020, 1'b1);
      push(13'h0000, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 13'h0028) begin
         errors++; $display("FAIL rst_fresh got valid=%b data=%h expected 1/0028", out_valid, out_data);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_mode_switch;
      out_ready = 1'b1;
      push(13'h0010, 1'b0);
      push(13'h0030, 1'b0);
      push(13'h0020, 1'b1);
      push(13'h0010, 1'b1);
      checks++;
      if (out_data !== 13'h0030) begin errors++; $display("FAIL mode_mid_max got %h expected 0030", out_data); end
      push(13'h0010, 1'b1);
      push(13'h0020, 1'b0);
      push(13'h0030, 1'b0);
      push(13'h0050, 1'b0);
      checks++;
      if (out_data !== 13'h002C) begin errors++; $display("FAIL mode_next_avg got %h expected 002c", out_data); end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      mode      = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      test_reset;
      test_max;
      test_average;
      test_backpressure;
      test_flush;
      test_mode_switch;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
